insight_tlc_trace_fifo: RTL and testbench
=========================================

INSIGHT_TLC_TRACE_FIFO -- requirements
Module: insight_tlc_trace_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, channel C data width in bits (power of 2, >=8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter SRC_W, default 1, source width.
REQ-004 SHALL have parameter SIZE_W, default 4, size field width.
REQ-005 SHALL have parameter DEPTH, default 8, trace entries (power of 2, >=2).
REQ-006 SHALL have port clock  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports c_ready, c_valid, c_corrupt  input  1 each  passive tap of channel C handshake and corrupt.
REQ-009 SHALL have ports c_opcode, c_param  input  3 each; c_size  input  SIZE_W; c_source  input  SRC_W; c_address  input  ADDR_W; c_data  input  DATA_W  tapped channel C fields.
REQ-010 SHALL have port out_valid  output  1, out_ready  input  1  trace dequeue handshake.
REQ-011 SHALL have ports out_opcode, out_param, out_size, out_source, out_address, out_data, out_corrupt  output  matching widths  head entry fields.
REQ-012 SHALL have ports out_first, out_last  output  1 each, out_beat  output  8  head entry burst position.
REQ-013 SHALL have ports err_stable, err_burst  output  1 each  sticky protocol errors.
REQ-014 SHALL have port drop_cnt  output  16  saturating dropped-beat count; err_clr  input  1  synchronous clear of errors and drop_cnt.

Function
REQ-015 SHALL treat a beat as fired when c_valid & c_ready are both 1 on a clock edge; block never drives channel C.
REQ-016 SHALL compute beats per message = 2^c_size / (DATA_W/8) when opcode is 1, 5 or 7 and 2^c_size > DATA_W/8; otherwise 1.
REQ-017 SHALL run burst FSM IDLE/BURST: IDLE + fired multi-beat first beat -> BURST with beat counter 1; BURST + fired beat with counter = beats-1 -> IDLE; single-beat messages stay IDLE.
REQ-018 SHALL latch opcode, param, size, source and address at first beat; in BURST any difference on a fired beat sets err_burst.
REQ-019 SHALL set err_stable when c_valid was 1 and c_ready 0 last cycle and this cycle c_valid drops to 0 or any field except c_data changes.
REQ-020 SHALL enqueue each fired beat with its fields, first = (counter 0), last = (counter = beats-1), beat = counter, one cycle after fire (registered, latency 1 to out_valid when empty).
REQ-021 SHALL pop head when out_valid & out_ready; out_* fields SHALL be held stable while out_valid & !out_ready.
REQ-022 SHALL accept enqueue when full only if a pop occurs the same cycle; otherwise beat dropped, drop_cnt += 1 saturating at 16'hFFFF.
REQ-023 SHALL advance burst FSM and counter on dropped beats identically to stored beats.
REQ-024 SHALL give err_clr priority over same-cycle error or drop events (result 0).
REQ-025 SHALL wrap read/write pointers modulo DEPTH, using an extra MSB to distinguish full from empty.

Reset
REQ-026 SHALL on reset: out_valid 0, pointers 0, FSM IDLE, counter 0, err_stable 0, err_burst 0, drop_cnt 0, history registers 0.
REQ-027 SHALL on reset mid-burst discard partial burst; next fired beat is treated as a first beat.
REQ-028 SHALL leave storage array contents unreset; out_* data fields are don't-care while out_valid 0.

Structure
REQ-029 SHALL place TL-C opcode constants (AccessAckData=1, ProbeAckData=5, ReleaseData=7) and the has-data function in shared package insight_tl_pkg.
REQ-030 SHALL implement storage as one sub-module insight_trace_ram (DEPTH x record width, one write, one async read port).

Verification
REQ-031 SHALL test: DATA_W=32, ReleaseData size=4 fired 4 consecutive cycles -> 4 entries, beat 0..3, first on 0, last on 3, no errors.
REQ-032 SHALL test: out_ready=0, 9 single-beat ProbeAck beats, DEPTH=8 -> 8 entries stored, drop_cnt=1.
REQ-033 SHALL test: full FIFO, fire and pop same cycle -> entry accepted, drop_cnt unchanged, occupancy stays 8.
REQ-034 SHALL test: c_valid=1,c_ready=0, address 0x1000 then 0x1004 next cycle -> err_stable=1 until err_clr.
REQ-035 SHALL test: ReleaseData size=4, beat 2 with source flipped -> err_burst=1, FSM returns IDLE after beat 3.
REQ-036 SHALL test: reset asserted after beat 1 of a 4-beat burst -> out_valid 0 immediately; next fired beat has first=1, beat=0.

Source files
------------

// File: rtl/insight_tl_pkg.sv
// Shared TileLink channel C definitions for the trace tap: opcode
// constants, the has-data classifier and the burst tracker state type.
package insight_tl_pkg;

  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] TL_PROBE_ACK_DATA  = 3'd5;
  localparam logic [2:0] TL_RELEASE_DATA    = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } burstState_t;

  // True for channel C messages that carry a data payload (may be multi-beat)
  function automatic logic tlHasData(input logic [2:0] opcode);
    return (opcode == TL_ACCESS_ACK_DATA) ||
           (opcode == TL_PROBE_ACK_DATA)  ||
           (opcode == TL_RELEASE_DATA);
  endfunction

endpackage

// File: rtl/insight_trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read
// port. Contents are deliberately not reset; validity is tracked by the
// FIFO pointers.
module insight_trace_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     writeEn,
  input  logic [$clog2(DEPTH)-1:0] writeAddr,
  input  logic [WIDTH-1:0]         writeData,
  input  logic [$clog2(DEPTH)-1:0] readAddr,
  output logic [WIDTH-1:0]         readData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Capture a new trace record on the write port
  always_ff @(posedge clock) begin
    if (writeEn) mem[writeAddr] <= writeData;
  end

  assign readData = mem[readAddr];

endmodule

// File: rtl/insight_tlc_trace_fifo.sv
// Passive channel C trace tap: records every fired beat with its burst
// position into a small FIFO, and flags handshake-stability and
// intra-burst field-consistency violations.
module insight_tlc_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SRC_W  = 1,
  parameter int SIZE_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_ready,
  input  logic              c_valid,
  input  logic              c_corrupt,
  input  logic [2:0]        c_opcode,
  input  logic [2:0]        c_param,
  input  logic [SIZE_W-1:0] c_size,
  input  logic [SRC_W-1:0]  c_source,
  input  logic [ADDR_W-1:0] c_address,
  input  logic [DATA_W-1:0] c_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_opcode,
  output logic [2:0]        out_param,
  output logic [SIZE_W-1:0] out_size,
  output logic [SRC_W-1:0]  out_source,
  output logic [ADDR_W-1:0] out_address,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corrupt,
  output logic              out_first,
  output logic              out_last,
  output logic [7:0]        out_beat,
  output logic              err_stable,
  output logic              err_burst,
  output logic [15:0]       drop_cnt,
  input  logic              err_clr
);

  import insight_tl_pkg::*;

  localparam int          PTR_W          = $clog2(DEPTH);
  localparam int          BEAT_SHIFT     = $clog2(DATA_W / 8);
  localparam logic [31:0] BYTES_PER_BEAT = 32'(DATA_W / 8);
  localparam int          REC_W          = 3 + 3 + SIZE_W + SRC_W + ADDR_W + DATA_W + 1 + 1 + 1 + 8;
  localparam logic [PTR_W:0] PTR_ONE     = (PTR_W + 1)'(1);

  // Number of channel beats a message occupies given its opcode and size
  function automatic logic [31:0] beatsFor(input logic [2:0] op, input logic [SIZE_W-1:0] sz);
    logic [31:0] bytes;
    bytes = 32'd1 << sz;
    if (tlHasData(op) && (bytes > BYTES_PER_BEAT)) return bytes >> BEAT_SHIFT;
    return 32'd1;
  endfunction

  burstState_t       state;
  logic [31:0]       beatCnt;
  logic [31:0]       latBeats;
  logic [2:0]        latOpcode;
  logic [2:0]        latParam;
  logic [SIZE_W-1:0] latSize;
  logic [SRC_W-1:0]  latSource;
  logic [ADDR_W-1:0] latAddress;

  logic              prevValid;
  logic              prevReady;
  logic              prevCorrupt;
  logic [2:0]        prevOpcode;
  logic [2:0]        prevParam;
  logic [SIZE_W-1:0] prevSize;
  logic [SRC_W-1:0]  prevSource;
  logic [ADDR_W-1:0] prevAddress;

  logic [PTR_W:0]    wrPtr;
  logic [PTR_W:0]    rdPtr;
  logic [15:0]       dropCnt;
  logic              errStable;
  logic              errBurst;

  logic              fire;
  logic [31:0]       curBeats;
  logic              isFirst;
  logic              isLast;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              burstMismatch;
  logic              stableViolation;
  logic [REC_W-1:0]  wrRecord;
  logic [REC_W-1:0]  rdRecord;

  assign fire     = c_valid & c_ready;
  assign curBeats = (state == IDLE) ? beatsFor(c_opcode, c_size) : latBeats;
  assign isFirst  = (beatCnt == 32'd0);
  assign isLast   = (beatCnt == (curBeats - 32'd1));

  assign full      = (wrPtr[PTR_W] != rdPtr[PTR_W]) && (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign out_valid = (wrPtr != rdPtr);
  assign pop       = out_valid & out_ready;
  assign push      = fire & (~full | pop);
  assign drop      = fire & full & ~pop;

  assign burstMismatch = (state == BURST) & fire &
                         ((c_opcode != latOpcode) || (c_param != latParam) ||
                          (c_size != latSize) || (c_source != latSource) ||
                          (c_address != latAddress));

  assign stableViolation = prevValid & ~prevReady &
                           (~c_valid || (c_opcode != prevOpcode) || (c_param != prevParam) ||
                            (c_size != prevSize) || (c_source != prevSource) ||
                            (c_address != prevAddress) || (c_corrupt != prevCorrupt));

  assign wrRecord = {c_opcode, c_param, c_size, c_source, c_address, c_data,
                     c_corrupt, isFirst, isLast, beatCnt[7:0]};

  assign {out_opcode, out_param, out_size, out_source, out_address, out_data,
          out_corrupt, out_first, out_last, out_beat} = rdRecord;

  assign err_stable = errStable;
  assign err_burst  = errBurst;
  assign drop_cnt   = dropCnt;

  // Burst tracker: counts beats of multi-beat messages, stored or dropped alike
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      beatCnt    <= 32'd0;
      latBeats   <= 32'd1;
      latOpcode  <= '0;
      latParam   <= '0;
      latSize    <= '0;
      latSource  <= '0;
      latAddress <= '0;
    end else if (fire) begin
      case (state)
        IDLE: begin
          if (curBeats > 32'd1) begin
            state      <= BURST;
            beatCnt    <= 32'd1;
            latBeats   <= curBeats;
            latOpcode  <= c_opcode;
            latParam   <= c_param;
            latSize    <= c_size;
            latSource  <= c_source;
            latAddress <= c_address;
          end
        end
        BURST: begin
          if (isLast) begin
            state   <= IDLE;
            beatCnt <= 32'd0;
          end else begin
            beatCnt <= beatCnt + 32'd1;
          end
        end
        default: begin
          state   <= IDLE;
          beatCnt <= 32'd0;
        end
      endcase
    end
  end

  // Previous-cycle snapshot of the channel used for the stall-stability check
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prevValid   <= 1'b0;
      prevReady   <= 1'b0;
      prevCorrupt <= 1'b0;
      prevOpcode  <= '0;
      prevParam   <= '0;
      prevSize    <= '0;
      prevSource  <= '0;
      prevAddress <= '0;
    end else begin
      prevValid   <= c_valid;
      prevReady   <= c_ready;
      prevCorrupt <= c_corrupt;
      prevOpcode  <= c_opcode;
      prevParam   <= c_param;
      prevSize    <= c_size;
      prevSource  <= c_source;
      prevAddress <= c_address;
    end
  end

  // Sticky error flags and saturating drop counter; clear wins over new events
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      errStable <= 1'b0;
      errBurst  <= 1'b0;
      dropCnt   <= 16'd0;
    end else if (err_clr) begin
      errStable <= 1'b0;
      errBurst  <= 1'b0;
      dropCnt   <= 16'd0;
    end else begin
      if (stableViolation) errStable <= 1'b1;
      if (burstMismatch)   errBurst  <= 1'b1;
      if (drop && (dropCnt != 16'hFFFF)) dropCnt <= dropCnt + 16'd1;
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
    end
  end

  insight_trace_ram #(
    .DEPTH(DEPTH),
    .WIDTH(REC_W)
  ) traceRam (
    .clock    (clock),
    .writeEn  (push),
    .writeAddr(wrPtr[PTR_W-1:0]),
    .writeData(wrRecord),
    .readAddr (rdPtr[PTR_W-1:0]),
    .readData (rdRecord)
  );

endmodule

// File: tb/tb_insight_tlc_trace_fifo.sv
// Directed self-checking bench for the channel C trace FIFO.
module tb_insight_tlc_trace_fifo;

  logic        clock;
  logic        reset;
  logic        c_ready;
  logic        c_valid;
  logic        c_corrupt;
  logic [2:0]  c_opcode;
  logic [2:0]  c_param;
  logic [3:0]  c_size;
  logic [0:0]  c_source;
  logic [31:0] c_address;
  logic [31:0] c_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [2:0]  out_param;
  logic [3:0]  out_size;
  logic [0:0]  out_source;
  logic [31:0] out_address;
  logic [31:0] out_data;
  logic        out_corrupt;
  logic        out_first;
  logic        out_last;
  logic [7:0]  out_beat;
  logic        err_stable;
  logic        err_burst;
  logic [15:0] drop_cnt;
  logic        err_clr;

  int assertCount;
  int failCount;

  insight_tlc_trace_fifo #(
    .DATA_W(32), .ADDR_W(32), .SRC_W(1), .SIZE_W(4), .DEPTH(8)
  ) dut (
    .clock(clock), .reset(reset),
    .c_ready(c_ready), .c_valid(c_valid), .c_corrupt(c_corrupt),
    .c_opcode(c_opcode), .c_param(c_param), .c_size(c_size),
    .c_source(c_source), .c_address(c_address), .c_data(c_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_param(out_param), .out_size(out_size),
    .out_source(out_source), .out_address(out_address), .out_data(out_data),
    .out_corrupt(out_corrupt), .out_first(out_first), .out_last(out_last),
    .out_beat(out_beat), .err_stable(err_stable), .err_burst(err_burst),
    .drop_cnt(drop_cnt), .err_clr(err_clr)
  );

  // Free-running clock, period 10
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of channel C and advance past the next rising edge
  task automatic applyStimulus(input logic v, input logic r, input logic [2:0] op,
                               input logic [3:0] sz, input logic src,
                               input logic [31:0] addr, input logic [31:0] data);
    c_valid   = v;
    c_ready   = r;
    c_opcode  = op;
    c_size    = sz;
    c_source  = src;
    c_address = addr;
    c_data    = data;
    @(posedge clock);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 32'h0, 32'h0);
  endtask

  // Check the head entry, then pop it over one edge
  task automatic popCheck(input string tag, input logic [7:0] expBeat, input logic expFirst,
                          input logic expLast, input logic [31:0] expData);
    checkOutput({tag, ".valid"}, 64'(out_valid), 64'd1);
    checkOutput({tag, ".beat"},  64'(out_beat),  64'(expBeat));
    checkOutput({tag, ".first"}, 64'(out_first), 64'(expFirst));
    checkOutput({tag, ".last"},  64'(out_last),  64'(expLast));
    checkOutput({tag, ".data"},  64'(out_data),  64'(expData));
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset     = 1'b1;
    c_valid   = 1'b0;
    c_ready   = 1'b0;
    c_corrupt = 1'b0;
    c_opcode  = 3'd0;
    c_param   = 3'd0;
    c_size    = 4'd0;
    c_source  = 1'b0;
    c_address = 32'h0;
    c_data    = 32'h0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    checkOutput("reset.out_valid",  64'(out_valid),  64'd0);
    checkOutput("reset.err_stable", 64'(err_stable), 64'd0);
    checkOutput("reset.err_burst",  64'(err_burst),  64'd0);
    checkOutput("reset.drop_cnt",   64'(drop_cnt),   64'd0);

    // ReleaseData, 16 bytes over a 4-byte bus: four beats
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd7, 4'd4, 1'b0, 32'h2000, 32'hA0 + 32'(i));
      if (i == 0) checkOutput("burst.latency", 64'(out_valid), 64'd1);
    end
    idleCycle();
    for (int i = 0; i < 4; i++)
      popCheck("burst", 8'(i), (i == 0), (i == 3), 32'hA0 + 32'(i));
    checkOutput("burst.empty",      64'(out_valid),  64'd0);
    checkOutput("burst.err_burst",  64'(err_burst),  64'd0);
    checkOutput("burst.err_stable", 64'(err_stable), 64'd0);

    // Nine single-beat ProbeAcks into an 8-deep FIFO with no draining
    for (int i = 0; i < 9; i++)
      applyStimulus(1'b1, 1'b1, 3'd4, 4'd2, 1'b0, 32'h3000, 32'(i));
    idleCycle();
    checkOutput("overflow.drop_cnt", 64'(drop_cnt), 64'd1);
    for (int i = 0; i < 8; i++)
      popCheck("overflow", 8'd0, 1'b1, 1'b1, 32'(i));
    checkOutput("overflow.empty", 64'(out_valid), 64'd0);

    // Clear the drop counter, refill, then push and pop together while full
    err_clr = 1'b1;
    idleCycle();
    err_clr = 1'b0;
    checkOutput("clr.drop_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 1'b1, 3'd4, 4'd2, 1'b0, 32'h4000, 32'h10 + 32'(i));
    checkOutput("full.head", 64'(out_data), 64'h10);
    out_ready = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'd4, 4'd2, 1'b0, 32'h4000, 32'h18);
    out_ready = 1'b0;
    idleCycle();
    checkOutput("fullpop.drop_cnt", 64'(drop_cnt), 64'd0);
    for (int i = 1; i < 9; i++)
      popCheck("fullpop", 8'd0, 1'b1, 1'b1, 32'h10 + 32'(i));
    checkOutput("fullpop.empty", 64'(out_valid), 64'd0);

    // Address changes while stalled
    applyStimulus(1'b1, 1'b0, 3'd4, 4'd2, 1'b0, 32'h1000, 32'h0);
    checkOutput("stable.before", 64'(err_stable), 64'd0);
    applyStimulus(1'b1, 1'b0, 3'd4, 4'd2, 1'b0, 32'h1004, 32'h0);
    checkOutput("stable.set", 64'(err_stable), 64'd1);
    idleCycle();
    idleCycle();
    checkOutput("stable.sticky", 64'(err_stable), 64'd1);
    checkOutput("stable.nofire", 64'(out_valid),  64'd0);
    err_clr = 1'b1;
    idleCycle();
    err_clr = 1'b0;
    checkOutput("stable.clr", 64'(err_stable), 64'd0);

    // Source flips on beat 2 of a four-beat ReleaseData
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd7, 4'd4, (i == 2), 32'h5000, 32'hB0 + 32'(i));
      if (i == 1) checkOutput("burst_err.before", 64'(err_burst), 64'd0);
      if (i == 2) checkOutput("burst_err.set",    64'(err_burst), 64'd1);
    end
    applyStimulus(1'b1, 1'b1, 3'd4, 4'd2, 1'b0, 32'h6000, 32'hC0);
    idleCycle();
    checkOutput("burst_err.sticky", 64'(err_burst),  64'd1);
    checkOutput("burst_err.stable", 64'(err_stable), 64'd0);
    popCheck("burst_err0", 8'd0, 1'b1, 1'b0, 32'hB0);
    popCheck("burst_err1", 8'd1, 1'b0, 1'b0, 32'hB1);
    checkOutput("burst_err2.source", 64'(out_source), 64'd1);
    popCheck("burst_err2", 8'd2, 1'b0, 1'b0, 32'hB2);
    popCheck("burst_err3", 8'd3, 1'b0, 1'b1, 32'hB3);
    popCheck("burst_err.idle", 8'd0, 1'b1, 1'b1, 32'hC0);
    err_clr = 1'b1;
    idleCycle();
    err_clr = 1'b0;
    checkOutput("burst_err.clr", 64'(err_burst), 64'd0);

    // Reset partway through a burst discards it
    applyStimulus(1'b1, 1'b1, 3'd7, 4'd4, 1'b0, 32'h7000, 32'hD0);
    applyStimulus(1'b1, 1'b1, 3'd7, 4'd4, 1'b0, 32'h7000, 32'hD1);
    c_valid = 1'b0;
    checkOutput("midreset.before", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("midreset.async", 64'(out_valid), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 3'd7, 4'd4, 1'b0, 32'h8000, 32'hE0);
    idleCycle();
    checkOutput("midreset.first", 64'(out_first), 64'd1);
    checkOutput("midreset.beat",  64'(out_beat),  64'd0);
    checkOutput("midreset.last",  64'(out_last),  64'd0);
    checkOutput("midreset.data",  64'(out_data),  64'hE0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
